// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the PC and fetches one N-bit word per instruction over a req/ack memory
// handshake. Each word is passed downstream on a valid/ready handshake. Jumps
// (jump_valid/jump_addr, driven by the Mux stage) redirect the PC in every state.
// Optional feature: define FETCH_STALL_CNT_EN to add the stall_cnt output.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   start                      run enable
//   jump_valid, jump_addr      PC redirect request and target
//   mem_req, mem_addr          memory read request and address (out)
//   mem_ack, mem_rdata         memory read response (in)
//   instr, instr_pc            fetched word and its address (out)
//   instr_valid, instr_ready   downstream handshake
//   busy                       high whenever the unit is not idle
//   stall_cnt                  saturating stall-cycle count (FETCH_STALL_CNT_EN only)
module fetch_unit #(
  parameter int unsigned   N        = 16,
  parameter logic [N-1:0]  RESET_PC = '0,
  parameter int unsigned   INC      = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         jump_valid,
  input  logic [N-1:0] jump_addr,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic         busy
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  localparam int unsigned SCW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pc_q, pc_d;
  logic           pend_q, pend_d;
  logic [N-1:0]   tgt_q, tgt_d;
  logic [N-1:0]   instr_q, instr_d;
  logic [N-1:0]   ipc_q, ipc_d;
  logic           valid_q, valid_d;
  logic           mem_req_q;
  logic           busy_q;

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (jump_valid) pc_d = jump_addr;
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_ack) begin
          if (jump_valid || pend_q) begin
            // Word belongs to the old path: drop it and follow the newest target.
            pc_d    = jump_valid ? jump_addr : tgt_q;
            pend_d  = 1'b0;
            state_d = start ? S_REQ : S_IDLE;
          end else begin
            instr_d = mem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + N'(INC);
            state_d = S_HOLD;
          end
        end else if (jump_valid) begin
          // Request in flight stays up; remember where to go once it returns.
          pend_d = 1'b1;
          tgt_d  = jump_addr;
        end
      end
      S_HOLD: begin
        if (instr_ready || jump_valid) begin
          valid_d = 1'b0;
          if (jump_valid) pc_d = jump_addr;
          state_d = start ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      tgt_q     <= '0;
      instr_q   <= '0;
      ipc_q     <= '0;
      valid_q   <= 1'b0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      tgt_q     <= tgt_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      valid_q   <= valid_d;
      mem_req_q <= (state_d == S_REQ);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // PC only moves outside an outstanding request, so it doubles as the address.
  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;

`ifdef FETCH_STALL_CNT_EN
  logic [SCW-1:0] stall_q, stall_d;

  // Saturating count of cycles waiting on memory or downstream
  always_comb begin
    stall_d = stall_q;
    if (((state_q == S_REQ) && !mem_ack) || ((state_q == S_HOLD) && !instr_ready)) begin
      if (stall_q != {SCW{1'b1}}) stall_d = stall_q + SCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
